// File: rtl/scaling_feeder.sv
// -----------------------------------------------------------------------------
// scaling_feeder
//
// Frame-level sequencer for the 2x2 pixel scaler. It reads the source frame
// from a synchronous-read RAM and presents pixels A, B, C, D to the scaler in
// the cycles the scaler samples them. It also writes the scaler's result
// pixel(s) to a destination RAM at consecutive addresses. Scaler enable and
// mode are owned here, so they stay stable for a whole frame.
//
// Tile schedule in RUN (P = 6 compress, P = 7 expand):
//   ph0..ph3 : source reads of A, B, C, D (data returns one cycle later)
//   ph1..ph4 : scl_pixel carries A, B, C, D
//   ph5      : write (compress WB2 / expand WB1)
//   ph6      : write (expand WB2 only)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              frame request, sampled only in IDLE
//   process_mode       0 = expand, 1 = compress; latched on an accepted start
//   busy, done         busy from ARM through the last RUN cycle; done pulse
//   src_rd_en/addr     source RAM read port (read data arrives the next cycle)
//   src_rdata          source RAM read data
//   scl_enable         scaler enable (ARM and RUN)
//   scl_process_mode   latched mode, driven to the scaler
//   scl_pixel          pixel to the scaler (passthrough of src_rdata)
//   scl_result         scaler output pixel
//   dst_wr_en/addr/wdata destination RAM write port
// -----------------------------------------------------------------------------
module scaling_feeder #(
  parameter int SRC_W_C = 512,
  parameter int SRC_W_E = 128,
  parameter int SRC_AW  = 18,
  parameter int DST_AW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              process_mode,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [23:0]       src_rdata,
  output logic              scl_enable,
  output logic              scl_process_mode,
  output logic [23:0]       scl_pixel,
  input  logic [23:0]       scl_result,
  output logic              dst_wr_en,
  output logic [DST_AW-1:0] dst_addr,
  output logic [23:0]       dst_wdata
);

  // Row strides are powers of two, so row*W is a shift by log2(W).
  localparam int LW_C = $clog2(SRC_W_C);
  localparam int LW_E = $clog2(SRC_W_E);

  // Tile counters are sized for whichever mode has more tiles per row.
  localparam int TMAX = (SRC_W_C / 2 > SRC_W_E) ? SRC_W_C / 2 : SRC_W_E;
  localparam int CW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] TL_C = CW'(SRC_W_C / 2 - 1);
  localparam logic [CW-1:0] TL_E = CW'(SRC_W_E - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [2:0]        ph_q, ph_d;
  logic [CW-1:0]     tx_q, tx_d;
  logic [CW-1:0]     ty_q, ty_d;
  logic [DST_AW-1:0] dst_q, dst_d;

  // ---------------------------------------------------------------------------
  // Source address generation (combinational from tile counters and phase).
  // ph[0] selects the right-hand column (B, D), ph[1] the lower row (C, D).
  // ---------------------------------------------------------------------------
  logic              step_x, step_y;
  logic [SRC_AW-1:0] col_c, row_c, col_e, row_e, rd_addr;

  always_comb begin
    step_x = ph_q[0];
    step_y = ph_q[1];
    // Compress: 2x2 stride, the neighbours are always inside the frame.
    col_c  = (SRC_AW'(tx_q) << 1) | SRC_AW'(step_x);
    row_c  = (SRC_AW'(ty_q) << 1) | SRC_AW'(step_y);
    // Expand: stride 1, the neighbour is clamped at the right/bottom edge.
    col_e  = SRC_AW'(tx_q) + SRC_AW'(step_x && (tx_q != TL_E));
    row_e  = SRC_AW'(ty_q) + SRC_AW'(step_y && (ty_q != TL_E));
    if (mode_q) begin
      rd_addr = (row_c << LW_C) + col_c;
    end else begin
      rd_addr = (row_e << LW_E) + col_e;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic          running;
  logic [2:0]    ph_last;
  logic [CW-1:0] tile_last;
  logic          last_tile;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    mode_d    = mode_q;
    ph_d      = ph_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    dst_d     = dst_q;

    running   = (state_q == S_RUN);
    ph_last   = mode_q ? 3'd5 : 3'd6;
    tile_last = mode_q ? TL_C : TL_E;
    last_tile = (tx_q == tile_last) && (ty_q == tile_last);

    busy      = (state_q == S_ARM) || running;
    scl_enable = busy;
    done      = (state_q == S_DONE);
    src_rd_en = running && (ph_q < 3'd4);
    dst_wr_en = running && ((ph_q == 3'd5) || (!mode_q && (ph_q == 3'd6)));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = process_mode;
          tx_d    = '0;
          ty_d    = '0;
          dst_d   = '0;
          ph_d    = '0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        ph_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (dst_wr_en) begin
          dst_d = dst_q + DST_AW'(1);
        end
        if (ph_q == ph_last) begin
          ph_d = '0;
          if (last_tile) begin
            state_d = S_DONE;
          end else if (tx_q == tile_last) begin
            tx_d = '0;
            ty_d = ty_q + CW'(1);
          end else begin
            tx_d = tx_q + CW'(1);
          end
        end else begin
          ph_d = ph_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Addresses are forced to 0 outside their strobes so idle outputs are quiet.
  assign src_addr         = src_rd_en ? rd_addr : '0;
  assign scl_process_mode = mode_q;
  assign scl_pixel        = src_rdata;
  assign dst_addr         = dst_q;
  assign dst_wdata        = scl_result;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      ph_q    <= '0;
      tx_q    <= '0;
      ty_q    <= '0;
      dst_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples values
      // from before the edge regardless of statement order.
      state_q <= state_d;
      mode_q  <= mode_d;
      ph_q    <= ph_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      dst_q   <= dst_d;
    end
  end

endmodule

// File: doc/scaling_feeder.md
Name: scaling_feeder

Overview:
- Frame-level sequencer that drives the 2x2 pixel scaler from its input side and collects its results on its output side.
- Reads the source frame from a synchronous RAM and presents pixels A, B, C, D to the scaler in the exact cycle slots the scaler samples them.
- Captures the scaler's writeback pixel(s) into a destination RAM at sequential addresses.
- Sits between the source frame buffer and the destination frame buffer. Owns scaler enable and mode so they stay stable for the whole frame.

Parameters:
- SRC_W_C, 512, source width/height in compress mode; 2x2 stride, one output per tile.
- SRC_W_E, 128, source width/height in expand mode; stride 1, two outputs per tile.
- SRC_AW, 18, source address width.
- DST_AW, 16, destination address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- process_mode  in  1  0 = expand, 1 = compress; latched on accepted start.
- busy  out  1  high from ARM through the last RUN cycle.
- done  out  1  one-cycle pulse at frame completion.
- src_rd_en  out  1  source RAM read strobe.
- src_addr  out  SRC_AW  source read address; data returns next cycle.
- src_rdata  in  24  source RAM read data.
- scl_enable  out  1  scaler enable.
- scl_process_mode  out  1  latched mode, driven to the scaler.
- scl_pixel  out  24  pixel to the scaler; combinational passthrough of src_rdata.
- scl_result  in  24  scaler output pixel.
- dst_wr_en  out  1  destination write strobe.
- dst_addr  out  DST_AW  destination write address.
- dst_wdata  out  24  equals scl_result in write cycles.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; all counters = 0.
  - busy, done, src_rd_en, dst_wr_en, scl_enable = 0.
  - scl_process_mode = 0; addresses = 0.
  - Applies mid-frame too: the frame is abandoned, no completion pulse.
- FSM states: IDLE -> ARM -> RUN -> DONE -> IDLE.
  - IDLE: start=1 latches mode, clears tile x/y and dst counter, moves to ARM.
  - ARM: one cycle, scl_enable=1, busy=1. The scaler spends this cycle in its NOP state.
  - RUN: scl_enable=1. Phase counter ph cycles 0..P-1, with P=6 in compress and P=7 in expand. Tile counters step in raster order when ph=P-1.
  - DONE: one cycle, done=1, busy=0, scl_enable=0. Moves to IDLE.
- Phase schedule inside RUN:
  - ph0 (scaler INIT): src_rd_en=1, src_addr=A.
  - ph1: src_addr=B. ph2: src_addr=C. ph3: src_addr=D.
  - ph1..ph4: scl_pixel carries A, B, C, D respectively.
  - Compress, ph5: dst_wr_en=1 (WB2).
  - Expand, ph5 and ph6: dst_wr_en=1 (WB1, then WB2).
  - src_rd_en=0 outside ph0..ph3.
- Addressing, with W the active width and address = row*W + col:
  - Compress tile (tx,ty), tx,ty in 0..W/2-1: A=(2tx,2ty), B=(2tx+1,2ty), C=(2tx,2ty+1), D=(2tx+1,2ty+1).
  - Expand tile (x,y), x,y in 0..W-1: A=(x,y), B=(min(x+1,W-1),y), C=(x,min(y+1,W-1)), D=(min(x+1,W-1),min(y+1,W-1)). Edge clamp, no wrap.
  - dst_addr starts at 0 and increments by 1 after every write. No gaps.
  - Total writes: compress (W/2)^2, expand 2*W^2.
- Last tile: after the final write cycle, RUN goes directly to DONE.
- done timing: done is high exactly 2 + tiles*P cycles after the start-accept edge.
- start is ignored while in ARM, RUN or DONE.
- process_mode changes mid-frame have no effect.
- The scaler's 200 ms input is outside this block and must be held 0 while busy=1. If it is not, output is undefined.
- Arithmetic: tile counters are log2(W) bits; row*W is a shift because W is a power of two. Address computation is combinational from the counters and ph.

Test Plan:
- Reset mid-frame: assert rst_n=0 at ph2 of tile 1 -> all outputs 0 immediately; no done pulse. A new start after release runs a full frame from tile 0.
- Compress order (SRC_W_C=4, pixel = address in each byte):
  - src_addr sequence 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15.
  - Exactly 4 writes at dst_addr 0..3.
  - done 26 cycles after start.
- Expand edge clamp (SRC_W_E=4):
  - Tile (3,0) reads 3,3,7,7.
  - Tile (3,3) reads 15,15,15,15.
  - 32 writes at dst_addr 0..31; done 114 cycles after start.
- Result capture: bench scaler returns scl_result = 0xA5A500+dst index -> each dst_wdata matches in its write cycle. dst_wr_en is never high in ph0..ph4.
- Start/mode robustness:
  - Pulse start and toggle process_mode during RUN -> ignored; schedule unchanged.
  - Start held high through DONE -> next frame begins one cycle after IDLE is re-entered.
- Enable timing: scl_enable rises one cycle before the first src_rd_en and falls in the DONE cycle. scl_pixel equals src_rdata in ph1..ph4 of every tile.
